// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit, 4-register MIPS: opcodes, instruction
// field positions and the decoded control bundle.
package mips16_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;

    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int RS_HI = 11;
    localparam int RS_LO = 10;
    localparam int RT_HI = 9;
    localparam int RT_LO = 8;
    localparam int RD_HI = 7;
    localparam int RD_LO = 6;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] dst;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_ctrl.sv
// Combinational instruction decoder: control bundle, which fields are read
// as sources, and the sign-extended immediate.
import mips16_pkg::*;

module decode_ctrl #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8
) (
    input  logic [15:0]       instr,
    output ctrl_t             ctrl,
    output logic              use_rs,
    output logic              use_rt,
    output logic [DATA_W-1:0] imm
);

    assign imm = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};

    always_comb begin
        ctrl   = '0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        case (instr[OP_HI:OP_LO])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                ctrl.regwrite = 1'b1;
                ctrl.dst      = instr[RD_HI:RD_LO];
                use_rs        = 1'b1;
                use_rt        = 1'b1;
            end
            OP_ADDI: begin
                ctrl.regwrite = 1'b1;
                ctrl.dst      = instr[RT_HI:RT_LO];
                use_rs        = 1'b1;
            end
            OP_LW: begin
                ctrl.regwrite = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.dst      = instr[RT_HI:RT_LO];
                use_rs        = 1'b1;
            end
            OP_SW: begin
                ctrl.memwrite = 1'b1;
                use_rs        = 1'b1;
                use_rt        = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                use_rs      = 1'b1;
                use_rt      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// ID stage: one-entry instruction register, RAW scoreboard, EX pipeline register.
// Optional stall cycle counter enabled with `define DECODE_STALL_COUNT_EN.
import mips16_pkg::*;

module decode_stage #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_valid,
    input  logic [15:0]       if_instr,
    output logic              if_ready,
    output logic [1:0]        rr1,
    output logic [1:0]        rr2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic              wb_valid,
    input  logic [1:0]        wb_reg,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [3:0]        ex_op,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [1:0]        ex_dst,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic [15:0]       stall_count
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state, state_nxt;
    logic [15:0]       ir;
    logic [3:0]        sb, sb_nxt;
    ctrl_t             dec;
    logic              use_rs, use_rt;
    logic [DATA_W-1:0] dec_imm;
    logic              hazard, issue, load;

    assign rr1 = ir[RS_HI:RS_LO];
    assign rr2 = ir[RT_HI:RT_LO];

    decode_ctrl #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_ctrl (
        .instr  (ir),
        .ctrl   (dec),
        .use_rs (use_rs),
        .use_rt (use_rt),
        .imm    (dec_imm)
    );

    // r0 is never set in the scoreboard, so it can never raise a hazard
    assign hazard = (state == FULL) && ((use_rs && sb[rr1]) || (use_rt && sb[rr2]));

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        load      = 1'b0;
        if_ready  = 1'b0;
        case (state)
            EMPTY: begin
                if_ready = 1'b1;
                load     = if_valid;
                if (if_valid) state_nxt = FULL;
            end
            FULL: begin
                issue    = !hazard && (!ex_valid || ex_ready);
                if_ready = issue;
                load     = issue && if_valid;
                if (issue && !if_valid) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (load) ir <= if_instr;
        end
    end

    // set after clear so an issuing writer wins over a same-cycle writeback
    always_comb begin
        sb_nxt = sb;
        if (wb_valid) sb_nxt[wb_reg] = 1'b0;
        if (issue && dec.regwrite && dec.dst != 2'd0) sb_nxt[dec.dst] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sb <= '0;
        else          sb <= sb_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid    <= 1'b0;
            ex_op       <= '0;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_imm      <= '0;
            ex_dst      <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_branch   <= 1'b0;
        end else if (issue) begin
            ex_valid    <= 1'b1;
            ex_op       <= ir[OP_HI:OP_LO];
            ex_a        <= rd1;
            ex_b        <= rd2;
            ex_imm      <= dec_imm;
            ex_dst      <= dec.dst;
            ex_regwrite <= dec.regwrite;
            ex_memread  <= dec.memread;
            ex_memwrite <= dec.memwrite;
            ex_branch   <= dec.branch;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

`ifdef DECODE_STALL_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                          stall_count <= '0;
        else if (hazard && stall_count != '1)  stall_count <= stall_count + 16'd1;
    end
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Randomized + directed bench for decode_stage against a transaction-level model.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        if_valid;
    logic [15:0] if_instr;
    logic        if_ready;
    logic [1:0]  rr1, rr2;
    logic [15:0] rd1, rd2;
    logic        wb_valid;
    logic [1:0]  wb_reg;
    logic        ex_valid, ex_ready;
    logic [3:0]  ex_op;
    logic [15:0] ex_a, ex_b, ex_imm;
    logic [1:0]  ex_dst;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_branch;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b1;

    // register file contents seen through rr1/rr2
    logic [15:0] regs [4] = '{16'h0000, 16'h0011, 16'h0007, 16'h0005};
    assign rd1 = regs[rr1];
    assign rd2 = regs[rr2];

    always #5 clock = ~clock;

    decode_stage dut (
        .clock(clock), .reset_n(reset_n),
        .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
        .rr1(rr1), .rr2(rr2), .rd1(rd1), .rd2(rd2),
        .wb_valid(wb_valid), .wb_reg(wb_reg),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_dst(ex_dst),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
        .stall_count(stall_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit rw, mr, mw, br, src_s, src_t;
        logic [1:0] dst;
    } mdec_t;

    function automatic mdec_t mdec(input logic [15:0] w);
        mdec_t d;
        int op;
        op = int'(w[15:12]);
        d.rw = 0; d.mr = 0; d.mw = 0; d.br = 0; d.src_s = 0; d.src_t = 0; d.dst = 2'd0;
        if (op <= 4) begin d.rw = 1; d.src_s = 1; d.src_t = 1; d.dst = w[7:6]; end
        else if (op == 5) begin d.rw = 1; d.mr = 1; d.src_s = 1; d.dst = w[9:8]; end
        else if (op == 6) begin d.mw = 1; d.src_s = 1; d.src_t = 1; end
        else if (op == 7) begin d.rw = 1; d.src_s = 1; d.dst = w[9:8]; end
        else if (op == 8) begin d.br = 1; d.src_s = 1; d.src_t = 1; end
        return d;
    endfunction

    bit          m_hold_v = 0;
    logic [15:0] m_hold = '0;
    logic [3:0]  m_pend = '0;
    bit          m_exv = 0, m_rw = 0, m_mr = 0, m_mw = 0, m_br = 0;
    logic [3:0]  m_op = '0;
    logic [15:0] m_a = '0, m_b = '0, m_imm = '0;
    logic [1:0]  m_dst = '0;
    int          m_cnt = 0;

    function automatic bit m_hazard();
        mdec_t d;
        logic [1:0] s, t;
        d = mdec(m_hold);
        s = m_hold[11:10];
        t = m_hold[9:8];
        return m_hold_v && ((d.src_s && s != 0 && m_pend[s]) || (d.src_t && t != 0 && m_pend[t]));
    endfunction

    function automatic bit m_issue();
        return m_hold_v && !m_hazard() && (!m_exv || ex_ready);
    endfunction

    function automatic bit m_ifready();
        return !m_hold_v || m_issue();
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_hold_v = 0; m_hold = '0; m_pend = '0; m_exv = 0; m_op = '0;
            m_a = '0; m_b = '0; m_imm = '0; m_dst = '0;
            m_rw = 0; m_mr = 0; m_mw = 0; m_br = 0; m_cnt = 0;
        end else begin
            bit iss, acc, haz;
            mdec_t d;
            int v;
            iss = m_issue();
            acc = if_valid && m_ifready();
            haz = m_hazard();
            d = mdec(m_hold);
            if (iss) begin
                v = int'(m_hold[7:0]);
                if (v > 127) v = v - 256;
                m_exv = 1; m_op = m_hold[15:12];
                m_a = regs[m_hold[11:10]]; m_b = regs[m_hold[9:8]];
                m_imm = v[15:0]; m_dst = d.dst;
                m_rw = d.rw; m_mr = d.mr; m_mw = d.mw; m_br = d.br;
            end else if (ex_ready) begin
                m_exv = 0;
            end
            if (wb_valid) m_pend[wb_reg] = 1'b0;
            if (iss && d.rw && d.dst != 0) m_pend[d.dst] = 1'b1;
`ifdef DECODE_STALL_COUNT_EN
            if (haz && m_cnt < 65535) m_cnt++;
`else
            if (haz) m_cnt = 0;
`endif
            if (acc) begin m_hold = if_instr; m_hold_v = 1; end
            else if (iss) m_hold_v = 0;
            if (wb_valid && wb_reg != 0) regs[wb_reg] <= 16'($urandom);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("if_ready", if_ready, m_ifready());
            chk("rr1", rr1, m_hold[11:10]);
            chk("rr2", rr2, m_hold[9:8]);
            chk("ex_valid", ex_valid, m_exv);
            chk("ex_op", ex_op, m_op);
            chk("ex_a", ex_a, m_a);
            chk("ex_b", ex_b, m_b);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_dst", ex_dst, m_dst);
            chk("ex_regwrite", ex_regwrite, m_rw);
            chk("ex_memread", ex_memread, m_mr);
            chk("ex_memwrite", ex_memwrite, m_mw);
            chk("ex_branch", ex_branch, m_br);
            chk("stall_count", stall_count, m_cnt[15:0]);
        end
    end

    // inputs applied just after a rising edge; outputs settle by the falling edge
    task automatic step(input logic iv, input logic [15:0] ins, input logic er,
                        input logic wv, input logic [1:0] wr);
        @(posedge clock); #1;
        if_valid = iv; if_instr = ins; ex_ready = er; wb_valid = wv; wb_reg = wr;
        @(negedge clock); #1;
    endtask

    localparam logic [31:0] STALLS_EXP =
`ifdef DECODE_STALL_COUNT_EN
        32'd3;
`else
        32'd0;
`endif

    initial begin
        reset_n = 1'b0; if_valid = 1'b1; if_instr = 16'h0E40;
        ex_ready = 1'b1; wb_valid = 1'b0; wb_reg = 2'd0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_ex_a", ex_a, 0);
        chk("rst_ex_op", ex_op, 0);
        @(posedge clock); #1;
        reset_n = 1'b1; if_valid = 1'b0;

        // ADD r1,r3,r2 then dependent SUB r2,r1,r1
        step(1, 16'h0E40, 1, 0, 0); chk("add_acc", if_ready, 1);
        step(1, 16'h1580, 1, 0, 0); chk("sub_acc", if_ready, 1);
        step(0, 16'h0000, 1, 0, 0);
        chk("add_vld", ex_valid, 1); chk("add_op", ex_op, 0);
        chk("add_a", ex_a, 5); chk("add_b", ex_b, 7);
        chk("add_dst", ex_dst, 1); chk("add_rw", ex_regwrite, 1);
        chk("sub_stall1", if_ready, 0);
        step(0, 16'h0000, 1, 0, 0); chk("sub_stall2", if_ready, 0);
        step(0, 16'h0000, 1, 1, 1); chk("sub_stall3", if_ready, 0);
        step(0, 16'h0000, 1, 0, 0); chk("sub_issue", if_ready, 1);
        chk("stall_cnt", stall_count, STALLS_EXP);
        step(1, 16'h72FF, 1, 0, 0);
        chk("sub_op", ex_op, 1); chk("sub_dst", ex_dst, 2); chk("addi_acc", if_ready, 1);
        step(1, 16'h00C0, 1, 0, 0); chk("addi_issue", if_ready, 1);
        step(0, 16'h0000, 1, 0, 0);
        chk("addi_imm", ex_imm, 16'hFFFF); chk("addi_dst", ex_dst, 2);
        chk("addi_op", ex_op, 7); chk("r0_nostall", if_ready, 1);
        // EX back-pressure
        step(1, 16'h3040, 0, 0, 0); chk("bp_load", if_ready, 1);
        chk("bp_op0", ex_op, 0); chk("bp_dst0", ex_dst, 3);
        step(1, 16'h2000, 0, 0, 0); chk("bp_block1", if_ready, 0);
        chk("bp_op1", ex_op, 0); chk("bp_dst1", ex_dst, 3); chk("bp_vld1", ex_valid, 1);
        step(1, 16'h2000, 0, 0, 0); chk("bp_block2", if_ready, 0);
        chk("bp_dst2", ex_dst, 3);
        step(1, 16'h2000, 1, 0, 0); chk("bp_resume", if_ready, 1);
        step(0, 16'h0000, 1, 0, 0); chk("or_op", ex_op, 3); chk("or_dst", ex_dst, 1);
        step(1, 16'h5300, 1, 0, 0); chk("and_op", ex_op, 2);
        // LW r3 issues alongside a writeback of r3: pending bit must survive
        step(0, 16'h0000, 1, 1, 3); chk("lw_issue", if_ready, 1);
        step(1, 16'h6C00, 1, 0, 0);
        chk("lw_op", ex_op, 5); chk("lw_mr", ex_memread, 1); chk("lw_dst", ex_dst, 3);
        step(0, 16'h0000, 1, 0, 0); chk("sw_haz", if_ready, 0);
        step(0, 16'h0000, 1, 1, 3); chk("sw_haz2", if_ready, 0);
        step(0, 16'h0000, 1, 0, 0); chk("sw_issue", if_ready, 1);
        step(0, 16'h0000, 1, 0, 0); chk("sw_op", ex_op, 6); chk("sw_mw", ex_memwrite, 1);

        for (int i = 0; i < 3000; i++)
            step(($urandom % 3) != 0, 16'($urandom), ($urandom % 4) != 0,
                 ($urandom % 3) == 0, 2'($urandom));

        // asynchronous reset in mid-cycle
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        chk("arst_ex_valid", ex_valid, 0);
        chk("arst_stall", stall_count, 0);
        chk("arst_if_ready", if_ready, 1);
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 200; i++)
            step(($urandom % 3) != 0, 16'($urandom), ($urandom % 4) != 0,
                 ($urandom % 3) == 0, 2'($urandom));

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
